pie_encoder: RTL

Reader-side downlink encoder that sits directly downstream of the carrier clock divider. It takes the divided carrier square wave and a byte to send. It gates the carrier with a Pulse-Interval-Encoded (PIE) envelope: a low delimiter, then 8 data symbols MSB-first, then the carrier returns to continuous-on. All timing is counted in carrier periods, detected as carrier rising edges inside the single system clock domain.

---
 rtl/rfid_pkg.sv | 18 +
 rtl/rise_tick.sv | 23 ++
 rtl/pie_encoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rfid_pkg.sv
// rfid_pkg: shared types and default timing for the reader-side PIE encoder
// and the tag-side decoder bench.
//   pie_state_t      - encoder FSM states
//   PIE_*_TICKS      - default symbol timing, in carrier periods
package rfid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELIM,
    SYM_HIGH,
    SYM_LOW
  } pie_state_t;

  localparam int PIE_TARI_TICKS  = 8;  // data-0 length; data-1 is twice this
  localparam int PIE_PW_TICKS    = 4;  // low pulse closing every symbol
  localparam int PIE_DELIM_TICKS = 6;  // carrier-off delimiter

endpackage

// File: rtl/rise_tick.sv
// rise_tick: one-clock pulse on each rising edge of a slow square wave that
// is sampled as data in the system clock domain.
//   clk  - system clock
//   rst  - synchronous active-high reset (clears the history flop)
//   sig  - slow input (e.g. divided carrier)
//   tick - sig & !sig_q
module rise_tick (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic tick
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign tick = sig & ~sig_q;

endmodule

// File: rtl/pie_encoder.sv
// pie_encoder: gates the divided carrier with a PIE envelope. A frame is a
// carrier-off delimiter followed by 8 symbols MSB-first; each symbol is a
// carrier-on phase and a PW_TICKS carrier-off pulse. All phases are timed in
// carrier rising edges (ticks); with no ticks the FSM simply holds.
//   clk_in     - system clock
//   rst_in     - synchronous active-high reset
//   carrier_in - divided carrier, sampled as data
//   data_in    - byte to send, taken on valid_in && ready_out
//   valid_in   - data_in valid
//   ready_out  - encoder idle
//   busy_out   - frame in progress (!ready_out)
//   env_out    - registered envelope, 1 = carrier on
//   tx_out     - carrier_in & env_out
// Legal parameters: 1 <= PW_TICKS < TARI_TICKS, DELIM_TICKS >= 1 and
// DELIM_TICKS <= 2*TARI_TICKS so the delimiter fits the phase counter.
module pie_encoder
  import rfid_pkg::*;
#(
  parameter int TARI_TICKS  = PIE_TARI_TICKS,
  parameter int PW_TICKS    = PIE_PW_TICKS,
  parameter int DELIM_TICKS = PIE_DELIM_TICKS
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       carrier_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       env_out,
  output logic       tx_out
);

  localparam int CNT_W = $clog2(2 * TARI_TICKS);

  // Last tick_cnt value of each phase.
  localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_TICKS - 1);
  localparam logic [CNT_W-1:0] HI0_LAST   = CNT_W'(TARI_TICKS - PW_TICKS - 1);
  localparam logic [CNT_W-1:0] HI1_LAST   = CNT_W'(2 * TARI_TICKS - PW_TICKS - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(PW_TICKS - 1);

  logic tick;

  rise_tick u_tick (
    .clk  (clk_in),
    .rst  (rst_in),
    .sig  (carrier_in),
    .tick (tick)
  );

  pie_state_t       state, state_n;
  logic             env, env_n;
  logic [7:0]       shift_reg, shift_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [CNT_W-1:0] tick_cnt, cnt_n;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      env       <= 1'b1;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tick_cnt  <= '0;
    end else begin
      state     <= state_n;
      env       <= env_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_n;
      tick_cnt  <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    env_n   = env;
    shift_n = shift_reg;
    bit_n   = bit_cnt;
    cnt_n   = tick_cnt;
    case (state)
      IDLE: begin
        // A tick on the accept edge is deliberately not counted: the
        // delimiter starts counting from the first tick after acceptance.
        if (valid_in) begin
          shift_n = data_in;
          bit_n   = 3'd7;
          cnt_n   = '0;
          env_n   = 1'b0;
          state_n = DELIM;
        end
      end
      DELIM: begin
        if (tick) begin
          if (tick_cnt == DELIM_LAST) begin
            env_n   = 1'b1;
            cnt_n   = '0;
            state_n = SYM_HIGH;
          end else begin
            cnt_n = tick_cnt + CNT_W'(1);
          end
        end
      end
      SYM_HIGH: begin
        // High phase length selects the symbol: data-1 is one Tari longer.
        if (tick) begin
          if (tick_cnt == (shift_reg[7] ? HI1_LAST : HI0_LAST)) begin
            env_n   = 1'b0;
            cnt_n   = '0;
            state_n = SYM_LOW;
          end else begin
            cnt_n = tick_cnt + CNT_W'(1);
          end
        end
      end
      SYM_LOW: begin
        if (tick) begin
          if (tick_cnt == LOW_LAST) begin
            env_n = 1'b1;
            cnt_n = '0;
            if (bit_cnt == 3'd0) begin
              state_n = IDLE;
            end else begin
              shift_n = {shift_reg[6:0], 1'b0};
              bit_n   = bit_cnt - 3'd1;
              state_n = SYM_HIGH;
            end
          end else begin
            cnt_n = tick_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        env_n   = 1'b1;
      end
    endcase
  end

  assign ready_out = (state == IDLE);
  assign busy_out  = ~ready_out;
  assign env_out   = env;
  assign tx_out    = carrier_in & env;

endmodule
